// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue
// ----------------------------------------------------------------------------
// Instruction prefetch queue sitting between the instruction memory port and
// the fetch/decode stage of the 3-stage RV32I core. It issues sequential word
// fetches ahead of decode and buffers up to DEPTH returned instructions
// together with their PCs. Decode drains the head under a valid/ready
// handshake. A redirect flushes the buffer, restarts fetch at the new target
// and silently discards every response still in flight from before it.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2); also caps the sum of
//             buffered entries and outstanding memory requests
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous reset, active low (rst=0 resets)
//   req_valid       fetch request valid                         (out)
//   req_addr[31:0]  word address of the fetch, [1:0] always 0   (out)
//   req_ready       memory accepts the request this cycle       (in)
//   rsp_valid       instruction word returned, in order         (in)
//   rsp_data[31:0]  returned instruction                        (in)
//   redirect_valid  flush and restart fetch                     (in)
//   redirect_pc     new fetch target, [1:0] ignored             (in)
//   out_valid       instruction available to decode             (out)
//   out_inst[31:0]  instruction at the head                     (out)
//   out_pc[31:0]    PC of out_inst                              (out)
//   out_ready       decode consumes the head this cycle         (in)
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined, a response arriving while the queue
//                          is empty (and nothing is being dropped) is shown
//                          to decode combinationally in the same cycle; if
//                          decode takes it, it never enters the buffer.
//                          Undefined: responses always pass through the
//                          buffer, one cycle response-to-decode latency.
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // One extra bit so count + outstanding cannot overflow before compare.
    localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    ptr_t        rd_ptr;
    ptr_t        wr_ptr;
    cnt_t        count;
    cnt_t        outstanding;
    cnt_t        drop_cnt;
    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;

    logic [CNT_W:0] occupancy;
    logic           room;
    logic           accept;
    logic           rsp_take;
    logic           rsp_keep;
    logic           queue_valid;
    logic           bypass;
    logic           push;
    logic           pop;
    logic [31:0]    target_pc;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    // Outstanding requests reserve a slot in the buffer, so a request is
    // only made when its response is guaranteed to find room.
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign room      = (occupancy < DEPTH_SUM);
    assign req_valid = rst & ~redirect_valid & room;
    assign req_addr  = fetch_pc;
    assign accept    = req_valid & req_ready;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // A response with nothing outstanding is a protocol violation and is
    // ignored entirely. Responses owed to pre-redirect requests are dropped
    // while drop_cnt is non-zero; any response in a redirect cycle is stale.
    assign rsp_take    = rsp_valid & (outstanding != '0);
    assign rsp_keep    = rsp_take & (drop_cnt == '0) & ~redirect_valid;
    assign queue_valid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass    = rsp_keep & ~queue_valid;
    assign out_valid = rst & ~redirect_valid & (queue_valid | bypass);
    assign out_inst  = queue_valid ? inst_mem[rd_ptr] : rsp_data;
    assign out_pc    = queue_valid ? pc_mem[rd_ptr]   : rsp_pc;
`else
    assign bypass    = 1'b0;
    assign out_valid = rst & ~redirect_valid & queue_valid;
    assign out_inst  = inst_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
`endif

    // A bypassed response that decode takes is consumed without touching
    // the buffer; one decode does not take is buffered as usual.
    assign pop  = out_valid & out_ready & queue_valid;
    assign push = rsp_keep & ~(bypass & out_ready);

    assign target_pc = {redirect_pc[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Control state update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
        end else if (redirect_valid) begin
            // No request is issued in a redirect cycle, so outstanding only
            // loses a response arriving now; everything left is stale.
            count       <= '0;
            rd_ptr      <= wr_ptr;
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc;
            outstanding <= outstanding - cnt_t'(rsp_take);
            drop_cnt    <= outstanding - cnt_t'(rsp_take);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + cnt_t'(accept) - cnt_t'(rsp_take);
            if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            // rsp_pc tracks every kept response, bypassed or buffered.
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Entry storage (data only, never reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue
// ----------------------------------------------------------------------------
// Randomized bench for fetch_queue. A memory model returns mem_word(addr)
// in order a few cycles after each accepted request. The reference model
// works at the level of the instruction stream: every request accepted since
// the last redirect/reset is owed to decode, in order, as {pc, mem_word(pc)};
// everything requested before a redirect is never delivered. Expected
// deliveries go into a queue; a separate monitor pops and compares on every
// decode handshake.
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          epoch = 0;
    int          cyc   = 0;
    logic [31:0] exp_req_pc;
    bit          rand_redir = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every decode handshake must deliver the oldest owed word.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got pc %h, expected no delivery (cycle %0d)", out_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_inst", out_inst, e.inst);
            end
        end
    end

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    // One clock cycle, entered just after a rising edge.
    task automatic step(input bit force_redir, input logic [31:0] target,
                        input int p_ready, input int p_out);
        int stale;
        bit redir;
        bit got;
        bit exp_rv;
        #1;
        redir = force_redir || (rand_redir && $urandom_range(0, 39) == 0);
        redirect_valid = redir;
        redirect_pc    = force_redir ? target : rand_target();
        req_ready      = ($urandom_range(0, 99) < p_ready);
        out_ready      = ($urandom_range(0, 99) < p_out);
        got       = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(0, 3) != 0) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mem_q[0].addr);
            got       = 1'b1;
        end
        #1;
        // Occupancy = words owed to decode + stale requests still in memory.
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        exp_rv = !redir && ((exp_q.size() + stale) < DEPTH);
        check("req_valid", req_valid, exp_rv);
        if (req_valid) check("req_addr", req_addr, exp_req_pc);
        if (redir) check("out_valid_redirect", out_valid, 1'b0);
        if (got) void'(mem_q.pop_front());
        if (req_valid && req_ready) begin
            mem_q.push_back('{req_addr, epoch, cyc + 1 + int'($urandom_range(0, 2))});
            exp_q.push_back('{exp_req_pc, mem_word(exp_req_pc)});
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_req_pc = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
    endtask

    // Reset asserted between edges; memory is reset alongside.
    task automatic async_reset();
        #1;
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("req_valid_in_reset", req_valid, 1'b0);
        check("out_valid_in_reset", out_valid, 1'b0);
        mem_q.delete();
        exp_q.delete();
        epoch++;
        exp_req_pc = RESET_PC;
        repeat (2) @(posedge clk);
        #2;
        check("req_valid_held_reset", req_valid, 1'b0);
        check("out_valid_held_reset", out_valid, 1'b0);
        #1;
        rst = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        exp_req_pc = RESET_PC;
        #3;
        check("req_valid_reset", req_valid, 1'b0);
        check("out_valid_reset", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);

        // Sequential fetch, everything ready.
        repeat (60) step(1'b0, '0, 100, 100);
        // Back-pressure: decode stalled, queue fills to DEPTH then stops.
        repeat (10) step(1'b0, '0, 100, 0);
        repeat (20) step(1'b0, '0, 100, 100);
        // Flush with requests in flight and entries queued.
        repeat (6) step(1'b0, '0, 100, 0);
        step(1'b1, 32'h0000_0100, 100, 100);
        repeat (20) step(1'b0, '0, 100, 100);
        // Misaligned target near the top of the address space.
        step(1'b1, 32'hFFFF_FFFE, 100, 100);
        repeat (20) step(1'b0, '0, 100, 100);
        // Memory stall.
        repeat (5) step(1'b0, '0, 0, 100);
        repeat (20) step(1'b0, '0, 100, 100);
        // Random traffic with random redirects.
        rand_redir = 1'b1;
        repeat (1500) step(1'b0, '0, 70, 60);
        // Fill up, then reset in the middle of it.
        rand_redir = 1'b0;
        repeat (8) step(1'b0, '0, 100, 0);
        async_reset();
        rand_redir = 1'b1;
        repeat (300) step(1'b0, '0, 70, 60);
        // Drain everything still owed.
        rand_redir = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && mem_q.size() == 0) break;
            step(1'b0, '0, 0, 100);
        end
        n_cmp++;
        if (exp_q.size() != 0 || mem_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d words still owed, %0d requests pending, expected 0",
                     exp_q.size(), mem_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
